// File: rtl/tile_pkg.sv
// Constants shared by the tile-map writer and the VGA renderer.
package tile_pkg;

    localparam int GRID_W = 20;
    localparam int GRID_H = 15;
    localparam int ADDR_W = 10;
    localparam int CELL_W = 4;

    localparam logic [3:0] TILE_WALL   = 4'b0000;
    localparam logic [3:0] TILE_FLOOR  = 4'b0001;
    localparam logic [3:0] TILE_PLAYER = 4'b0010;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CHK,
        ST_RDW,
        ST_EVAL,
        ST_WRN,
        ST_DONE
    } wr_state_e;

endpackage

// File: rtl/tile_addr.sv
// Combinational (column, row) to linear tile-map address: addr = y*GRID_W + x.
module tile_addr #(
    parameter int GRID_W = tile_pkg::GRID_W,
    parameter int ADDR_W = tile_pkg::ADDR_W,
    parameter int X_W    = 5,
    parameter int Y_W    = 4
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr
);

    assign addr = ADDR_W'(y) * ADDR_W'(GRID_W) + ADDR_W'(x);

endmodule

// File: rtl/player_tile_writer.sv
// Moves the player tile in the tile-map BRAM: bounds check, read target,
// then write floor to the old cell and the player code to the new one.
module player_tile_writer #(
    parameter int GRID_W  = tile_pkg::GRID_W,
    parameter int GRID_H  = tile_pkg::GRID_H,
    parameter int ADDR_W  = tile_pkg::ADDR_W,
    parameter int CELL_W  = tile_pkg::CELL_W,
    parameter int START_X = 10,
    parameter int START_Y = 7,
    parameter logic [CELL_W-1:0] TILE_FLOOR  = tile_pkg::TILE_FLOOR,
    parameter logic [CELL_W-1:0] TILE_PLAYER = tile_pkg::TILE_PLAYER,
    parameter logic [CELL_W-1:0] TILE_WALL   = tile_pkg::TILE_WALL
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Move_Valid,
    input  logic [1:0]        i_Move_Dir,
    output logic              o_Move_Ready,
    output logic              o_Move_Done,
    output logic              o_Move_Blocked,
    output logic [4:0]        o_Player_X,
    output logic [3:0]        o_Player_Y,
    output logic [ADDR_W-1:0] o_Bram_Addr_R,
    input  logic [CELL_W-1:0] i_Bram_Data_R,
    output logic [ADDR_W-1:0] o_Bram_Addr_W,
    output logic [CELL_W-1:0] o_Bram_Data_W,
    output logic              o_Bram_WE
);

    import tile_pkg::*;

    localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_Y * GRID_W + START_X);

    wr_state_e         state_q, state_d;
    dir_e              dir_q, dir_d;
    logic              blocked_q, blocked_d;
    logic [4:0]        x_q, x_d, tgt_x;
    logic [3:0]        y_q, y_d, tgt_y;
    logic              off_grid;
    logic [ADDR_W-1:0] cur_addr, tgt_addr;
    logic [ADDR_W-1:0] addr_r_d, addr_w_d;
    logic [CELL_W-1:0] data_w_d;
    logic              we_d, done_d, blk_out_d;

    tile_addr #(.GRID_W(GRID_W), .ADDR_W(ADDR_W), .X_W(5), .Y_W(4)) u_cur_addr (
        .x    (x_q),
        .y    (y_q),
        .addr (cur_addr)
    );

    tile_addr #(.GRID_W(GRID_W), .ADDR_W(ADDR_W), .X_W(5), .Y_W(4)) u_tgt_addr (
        .x    (tgt_x),
        .y    (tgt_y),
        .addr (tgt_addr)
    );

    // Target cell for the latched direction; off_grid flags a step past the border.
    always_comb begin
        tgt_x    = x_q;
        tgt_y    = y_q;
        off_grid = 1'b0;
        unique case (dir_q)
            DIR_UP: begin
                tgt_y    = y_q - 4'd1;
                off_grid = (y_q == 4'd0);
            end
            DIR_DOWN: begin
                tgt_y    = y_q + 4'd1;
                off_grid = (y_q == 4'(GRID_H - 1));
            end
            DIR_LEFT: begin
                tgt_x    = x_q - 5'd1;
                off_grid = (x_q == 5'd0);
            end
            DIR_RIGHT: begin
                tgt_x    = x_q + 5'd1;
                off_grid = (x_q == 5'(GRID_W - 1));
            end
            default: begin
                off_grid = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        blocked_d = blocked_q;
        x_d       = x_q;
        y_d       = y_q;
        addr_r_d  = o_Bram_Addr_R;
        addr_w_d  = o_Bram_Addr_W;
        data_w_d  = o_Bram_Data_W;
        we_d      = 1'b0;
        // Done is published the cycle after DONE, so it never overlaps the last write.
        done_d    = (state_q == ST_DONE);
        blk_out_d = (state_q == ST_DONE) && blocked_q;

        unique case (state_q)
            ST_INIT: begin
                we_d     = 1'b1;
                addr_w_d = START_ADDR;
                data_w_d = TILE_PLAYER;
                state_d  = ST_IDLE;
            end
            ST_IDLE: begin
                if (i_Move_Valid) begin
                    dir_d     = dir_e'(i_Move_Dir);
                    blocked_d = 1'b0;
                    state_d   = ST_CHK;
                end
            end
            ST_CHK: begin
                if (off_grid) begin
                    blocked_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    addr_r_d = tgt_addr;
                    state_d  = ST_RDW;
                end
            end
            ST_RDW: begin
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (i_Bram_Data_R == TILE_WALL) begin
                    blocked_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    we_d     = 1'b1;
                    addr_w_d = cur_addr;
                    data_w_d = TILE_FLOOR;
                    state_d  = ST_WRN;
                end
            end
            ST_WRN: begin
                we_d     = 1'b1;
                addr_w_d = tgt_addr;
                data_w_d = TILE_PLAYER;
                x_d      = tgt_x;
                y_d      = tgt_y;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q        <= ST_INIT;
            blocked_q      <= 1'b0;
            x_q            <= 5'(START_X);
            y_q            <= 4'(START_Y);
            o_Move_Done    <= 1'b0;
            o_Move_Blocked <= 1'b0;
            o_Bram_WE      <= 1'b0;
            o_Bram_Addr_R  <= '0;
            o_Bram_Addr_W  <= '0;
            o_Bram_Data_W  <= '0;
        end else begin
            state_q        <= state_d;
            blocked_q      <= blocked_d;
            x_q            <= x_d;
            y_q            <= y_d;
            o_Move_Done    <= done_d;
            o_Move_Blocked <= blk_out_d;
            o_Bram_WE      <= we_d;
            o_Bram_Addr_R  <= addr_r_d;
            o_Bram_Addr_W  <= addr_w_d;
            o_Bram_Data_W  <= data_w_d;
        end
    end

    // The latched direction is only consumed after a fresh acceptance.
    always_ff @(posedge i_Clk) begin
        dir_q <= dir_d;
    end

    assign o_Move_Ready = (state_q == ST_IDLE);
    assign o_Player_X   = x_q;
    assign o_Player_Y   = y_q;

endmodule

// File: tb/tb_player_tile_writer.sv
// Scoreboard bench for player_tile_writer with a BRAM model and a grid-level reference.
`timescale 1ns/1ps
module tb_player_tile_writer;

    localparam int GW = 20;
    localparam int GH = 15;
    localparam logic [3:0] WALL   = 4'b0000;
    localparam logic [3:0] FLOOR  = 4'b0001;
    localparam logic [3:0] PLAYER = 4'b0010;
    localparam int START_ADDR = 7 * GW + 10;

    typedef struct packed {
        logic       blk;
        logic [4:0] x;
        logic [3:0] y;
        logic [9:0] ra;
    } done_t;

    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Move_Valid = 1'b0;
    logic [1:0] i_Move_Dir = 2'd0;
    logic       o_Move_Ready, o_Move_Done, o_Move_Blocked, o_Bram_WE;
    logic [4:0] o_Player_X;
    logic [3:0] o_Player_Y;
    logic [9:0] o_Bram_Addr_R, o_Bram_Addr_W;
    logic [3:0] o_Bram_Data_W;
    logic [3:0] bram_rdata = 4'd0;

    player_tile_writer dut (
        .i_Clk          (i_Clk),
        .i_Reset        (i_Reset),
        .i_Move_Valid   (i_Move_Valid),
        .i_Move_Dir     (i_Move_Dir),
        .o_Move_Ready   (o_Move_Ready),
        .o_Move_Done    (o_Move_Done),
        .o_Move_Blocked (o_Move_Blocked),
        .o_Player_X     (o_Player_X),
        .o_Player_Y     (o_Player_Y),
        .o_Bram_Addr_R  (o_Bram_Addr_R),
        .i_Bram_Data_R  (bram_rdata),
        .o_Bram_Addr_W  (o_Bram_Addr_W),
        .o_Bram_Data_W  (o_Bram_Data_W),
        .o_Bram_WE      (o_Bram_WE)
    );

    always #20 i_Clk = ~i_Clk;

    // BRAM model: registered read, DUT write port plus a bench back-door port.
    logic [3:0] mem [0:1023];
    logic       tb_we = 1'b0;
    logic [9:0] tb_waddr = 10'd0;
    logic [3:0] tb_wdata = 4'd0;

    always @(posedge i_Clk) begin
        bram_rdata <= mem[o_Bram_Addr_R];
        if (o_Bram_WE) mem[o_Bram_Addr_W] <= o_Bram_Data_W;
        if (tb_we) mem[tb_waddr] <= tb_wdata;
    end

    // Reference model state
    logic [3:0]  map [0:299];
    int          px, py, undo_addr, acc_cnt;
    logic [9:0]  last_rd;
    logic [13:0] exp_wr[$];
    done_t       exp_done[$];
    int          vectors, miscompares;

    task automatic chk(input string nm, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: actual %0d required %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Acceptance monitor: applies the move rules at grid level and queues expectations.
    int  nx, ny, ta;
    bit  blk;
    always @(negedge i_Clk) begin
        if (!i_Reset && i_Move_Valid && o_Move_Ready) begin
            nx = px; ny = py; blk = 1'b0;
            case (i_Move_Dir)
                2'd0:    if (py == 0)      blk = 1'b1; else ny = py - 1;
                2'd1:    if (py == GH - 1) blk = 1'b1; else ny = py + 1;
                2'd2:    if (px == 0)      blk = 1'b1; else nx = px - 1;
                default: if (px == GW - 1) blk = 1'b1; else nx = px + 1;
            endcase
            if (!blk) begin
                ta = ny * GW + nx;
                last_rd = 10'(ta);
                if (map[ta] == WALL) blk = 1'b1;
            end
            if (!blk) begin
                exp_wr.push_back({10'(py * GW + px), FLOOR});
                exp_wr.push_back({10'(ta), PLAYER});
                map[py * GW + px] = FLOOR;
                map[ta] = PLAYER;
                undo_addr = ta;
                px = nx;
                py = ny;
            end
            exp_done.push_back(done_t'({blk, 5'(px), 4'(py), last_rd}));
            acc_cnt++;
        end
    end

    // Output monitor
    logic [13:0] w;
    done_t       d;
    always @(negedge i_Clk) begin
        if (o_Bram_WE) begin
            if (exp_wr.size() == 0) begin
                chk("unexpected_write_addr", int'(o_Bram_Addr_W), -1);
            end else begin
                w = exp_wr.pop_front();
                chk("write_addr", int'(o_Bram_Addr_W), int'(w[13:4]));
                chk("write_data", int'(o_Bram_Data_W), int'(w[3:0]));
            end
        end
        if (o_Move_Done) begin
            chk("done_we_overlap", int'(o_Bram_WE), 0);
            if (exp_done.size() == 0) begin
                chk("unexpected_done_x", int'(o_Player_X), -1);
            end else begin
                d = exp_done.pop_front();
                chk("blocked", int'(o_Move_Blocked), int'(d.blk));
                chk("player_x", int'(o_Player_X), int'(d.x));
                chk("player_y", int'(o_Player_Y), int'(d.y));
                chk("addr_r", int'(o_Bram_Addr_R), int'(d.ra));
            end
        end
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic poke(input int a, input logic [3:0] v);
        tb_we = 1'b1;
        tb_waddr = 10'(a);
        tb_wdata = v;
        map[a] = v;
        tick();
        tb_we = 1'b0;
    endtask

    task automatic do_reset(input bit init_map);
        bit ok;
        i_Reset = 1'b1;
        i_Move_Valid = 1'b0;
        if (exp_done.size() != 0 && !exp_done[0].blk) map[undo_addr] = FLOOR;
        exp_wr.delete();
        exp_done.delete();
        tick();
        if (init_map) for (int a = 0; a < 300; a++) poke(a, (a == 130) ? WALL : FLOOR);
        @(negedge i_Clk);
        chk("rst_ready", int'(o_Move_Ready), 0);
        chk("rst_done", int'(o_Move_Done), 0);
        chk("rst_blocked", int'(o_Move_Blocked), 0);
        chk("rst_we", int'(o_Bram_WE), 0);
        chk("rst_addr_r", int'(o_Bram_Addr_R), 0);
        chk("rst_addr_w", int'(o_Bram_Addr_W), 0);
        chk("rst_data_w", int'(o_Bram_Data_W), 0);
        chk("rst_x", int'(o_Player_X), 10);
        chk("rst_y", int'(o_Player_Y), 7);
        tick();
        px = 10; py = 7; last_rd = 10'd0;
        map[START_ADDR] = PLAYER;
        exp_wr.push_back({10'(START_ADDR), PLAYER});
        i_Reset = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_Clk);
            if (o_Move_Ready) begin ok = 1'b1; break; end
        end
        chk("ready_after_init", int'(ok), 1);
        chk("init_x", int'(o_Player_X), 10);
        chk("init_y", int'(o_Player_Y), 7);
        tick();
    endtask

    task automatic send(input logic [1:0] dir, input bit keep, input bit pulse);
        int  n;
        bit  ok;
        tick();
        i_Move_Valid = 1'b1;
        i_Move_Dir = dir;
        n = acc_cnt;
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (acc_cnt != n) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", acc_cnt, n + 1);
        if (!keep) begin
            i_Move_Valid = 1'b0;
            if (pulse) begin
                tick();
                i_Move_Valid = 1'b1;
                i_Move_Dir = 2'($urandom);
                tick();
                i_Move_Valid = 1'b0;
            end
        end
    endtask

    initial begin
        bit ok;
        bit keep;
        bit pulse;
        int a;
        vectors = 0; miscompares = 0; acc_cnt = 0; undo_addr = 0;
        px = 10; py = 7; last_rd = 10'd0;

        do_reset(1'b1);

        // Directed: wall above, one step right, walk to the left border, bump it.
        send(2'd0, 1'b0, 1'b0);
        send(2'd3, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) send(2'd2, 1'b0, 1'b0);
        send(2'd2, 1'b0, 1'b0);
        send(2'd3, 1'b0, 1'b1);

        // Reset while the old cell is being written.
        send(2'd3, 1'b0, 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (o_Bram_WE) begin ok = 1'b1; break; end
            tick();
        end
        chk("old_write_seen", int'(ok), 1);
        i_Reset = 1'b1;
        tick();
        chk("we_drop_on_reset", int'(o_Bram_WE), 0);
        do_reset(1'b0);

        // Random walk over a map with scattered walls.
        for (int i = 0; i < 60; i++) begin
            a = int'($urandom_range(0, 299));
            if (a != py * GW + px) poke(a, WALL);
        end
        for (int i = 0; i < 250; i++) begin
            keep = ($urandom_range(0, 3) == 0);
            pulse = !keep && ($urandom_range(0, 3) == 0);
            send(2'($urandom_range(0, 3)), keep, pulse);
            if (!keep) repeat ($urandom_range(0, 2)) tick();
        end
        i_Move_Valid = 1'b0;

        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (exp_wr.size() == 0 && exp_done.size() == 0) begin ok = 1'b1; break; end
        end
        chk("drain_pending", exp_wr.size() + exp_done.size(), 0);
        repeat (4) tick();
        chk("final_x", int'(o_Player_X), px);
        chk("final_y", int'(o_Player_Y), py);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
